// File: rtl/regblock_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing, flush and occupancy count.
// Define REGBLOCK_PIPE_STATS_EN to add the stall_cnt and full_seen statistics outputs.
module regblock_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
`ifdef REGBLOCK_PIPE_STATS_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic             full_seen
`endif
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_xfer, out_xfer;

  // A stage may advance if it is empty or the stage ahead of it advances.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !v_q[DEPTH-1] || out_ready;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      adv[i] = !v_q[i] || adv[i+1];
    end
  end

  assign in_ready  = adv[0] && !flush;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign out_xfer  = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (adv[0]) begin
      v_d[0] = in_xfer;
      if (in_xfer) begin
        d_d[0] = in_data;
      end
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (adv[i]) begin
        v_d[i] = v_q[i-1];
        d_d[i] = d_q[i-1];
      end
    end
    // Data may keep shifting on flush; only the valids matter.
    if (flush) begin
      v_d = '0;
    end
  end

  always_comb begin
    count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      d_q     <= '{default: '0};
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
    end
  end

`ifdef REGBLOCK_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      full_seen <= 1'b0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (count_q == CNT_W'(DEPTH)) begin
        full_seen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regblock_pipe.sv
// Directed self-checking bench for regblock_pipe at WIDTH=32, DEPTH=3.
// Statistics checks are compiled in when REGBLOCK_PIPE_STATS_EN is defined.
module tb_regblock_pipe;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  count;
`ifdef REGBLOCK_PIPE_STATS_EN
  logic [31:0] stall_cnt;
  logic        full_seen;
`endif
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regblock_pipe #(.WIDTH(32), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
`ifdef REGBLOCK_PIPE_STATS_EN
    , .stall_cnt(stall_cnt), .full_seen(full_seen)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'h1234; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++;
      $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (count !== 2'd0) begin n_fail++;
      $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++;
        $display("FAIL reset_no_capture cycle %0d out_valid got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_single_word();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL single_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; in_data = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      n_checks++; if (out_valid !== (c == 3)) begin n_fail++;
        $display("FAIL single_out_valid cycle %0d got %b want %b", c, out_valid, c == 3); end
      n_checks++; if (count !== ((c <= 3) ? 2'd1 : 2'd0)) begin n_fail++;
        $display("FAIL single_count cycle %0d got %0d want %0d", c, count, (c <= 3) ? 1 : 0); end
      if (c == 3) begin
        n_checks++; if (out_data !== 32'hDEADBEEF) begin n_fail++;
          $display("FAIL single_out_data got %h want deadbeef", out_data); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_out [4];
    exp_out = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'hA1 + 32'(k);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++;
        $display("FAIL bp_accept word %0d in_ready got %b want 1", k, in_ready); end
      tick();
    end
    in_data = 32'hA4;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
    n_checks++; if (count !== 2'd3) begin n_fail++;
      $display("FAIL bp_full_count got %0d want 3", count); end
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL bp_hold_in_ready got %b want 0", in_ready); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL bp_ripple_in_ready got %b want 1", in_ready); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp_out[k]) begin n_fail++;
        $display("FAIL bp_order word %0d got v=%b d=%h want v=1 d=%h",
                 k, out_valid, out_data, exp_out[k]); end
      n_checks++; if (count !== 2'(3 - ((k > 0) ? k - 1 : 0))) begin n_fail++;
        $display("FAIL bp_count word %0d got %0d want %0d", k, count, 3 - ((k > 0) ? k - 1 : 0)); end
      tick();
      in_valid = 1'b0;
    end
    n_checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin n_fail++;
      $display("FAIL bp_drained got v=%b cnt=%0d want v=0 cnt=0", out_valid, count); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      in_valid = (c < 10);
      in_data = 32'(c);
      #1;
      if (c < 10) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
          $display("FAIL stream_in_ready cycle %0d got %b want 1", c, in_ready); end
      end
      if (c >= 3 && c <= 12) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'(c - 3)) begin n_fail++;
          $display("FAIL stream_out cycle %0d got v=%b d=%0d want v=1 d=%0d",
                   c, out_valid, out_data, c - 3); end
      end else begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++;
          $display("FAIL stream_idle cycle %0d out_valid got %b want 0", c, out_valid); end
      end
      if (c >= 3 && c <= 10) begin
        n_checks++; if (count !== 2'd3) begin n_fail++;
          $display("FAIL stream_count cycle %0d got %0d want 3", c, count); end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_valid = 1'b0;
    #1;
    n_checks++; if (count !== 2'd2) begin n_fail++;
      $display("FAIL flush_pre_count got %0d want 2", count); end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h55;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL flush_in_ready got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (count !== 2'd0) begin n_fail++;
      $display("FAIL flush_count got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_out_valid got %b want 0", out_valid); end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++;
        $display("FAIL flush_leak cycle %0d got v=%b d=%h want v=0", c, out_valid, out_data); end
    end
  endtask

`ifdef REGBLOCK_PIPE_STATS_EN
  task automatic test_stats();
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    n_checks++; if (stall_cnt !== 32'd0 || full_seen !== 1'b0) begin n_fail++;
      $display("FAIL stats_reset got stall=%0d full=%b want 0 0", stall_cnt, full_seen); end
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'hB1 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    n_checks++; if (stall_cnt !== 32'd5) begin n_fail++;
      $display("FAIL stats_stall got %0d want 5", stall_cnt); end
    n_checks++; if (full_seen !== 1'b1) begin n_fail++;
      $display("FAIL stats_full_seen got %b want 1", full_seen); end
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_checks++; if (stall_cnt !== 32'd5 || full_seen !== 1'b1) begin n_fail++;
      $display("FAIL stats_after_flush got stall=%0d full=%b want 5 1", stall_cnt, full_seen); end
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    n_checks++; if (stall_cnt !== 32'd0 || full_seen !== 1'b0) begin n_fail++;
      $display("FAIL stats_rst_clear got stall=%0d full=%b want 0 0", stall_cnt, full_seen); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_streaming();
    test_flush();
`ifdef REGBLOCK_PIPE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regblock_pipe.md
Name: regblock_pipe

Overview:
- Parametrised successor to the single enabled register: a DEPTH-stage, WIDTH-bit register pipeline with valid/ready flow control on both sides.
- Bubble-collapsing, so stalls compress empty stages. Supports synchronous flush and reports occupancy.
- Used between producer and consumer blocks in miter/equivalence harnesses and datapaths needing fixed minimum latency with backpressure.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1); also the minimum latency in cycles.
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  producer has data.
- in_ready  output  1  pipeline accepts data this cycle.
- in_data  input  WIDTH  producer data.
- out_valid  output  1  final stage holds valid data.
- out_ready  input  1  consumer accepts data this cycle.
- out_data  output  WIDTH  final stage data.
- count  output  CNT_W  number of valid stages, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset: sampled at posedge. All stage valid bits clear to 0, all stage data clear to 0. Therefore out_valid=0, out_data=0, count=0, in_ready=1 in the cycle after reset. rst has priority over flush and all transfers. Reset mid-operation discards all contents.
- Stages: stage 0 is the input stage; stage DEPTH-1 drives out_valid/out_data directly from registers, with no combinational path from in_data to out_data.
- Advance rule, combinational from the output backwards:
  - adv[DEPTH-1] = !v[DEPTH-1] || out_ready
  - adv[i] = !v[i] || adv[i+1]
  - in_ready = adv[0] && !flush
- Stage i loads on posedge when adv[i]=1:
  - i>0: v[i] <= v[i-1], d[i] <= d[i-1]
  - stage 0: v[0] <= in_valid && in_ready, d[0] <= in_data when the transfer occurs
- Holding stages (adv[i]=0) keep valid and data unchanged.
- Input transfer occurs iff in_valid && in_ready. Output transfer occurs iff out_valid && out_ready.
- Latency: a word accepted at cycle t appears on out_valid at cycle t+DEPTH if the pipeline ahead is empty. Later under stalls; ordering is always preserved.
- Throughput: with out_ready held at 1, one word per cycle, with no bubbles inserted.
- Full: count==DEPTH and out_ready=0 -> in_ready=0.
- Full with out_ready=1: in_ready=1 in the same cycle (ready ripples back), so simultaneous push and pop is legal and count is unchanged.
- Flush (rst=0, flush=1):
  - All v[i] <= 0 at the next edge.
  - in_ready is forced 0, so no input is accepted.
  - out_valid/out_data still reflect current registers. An output transfer in the flush cycle is legal and counts as delivered.
  - Data registers need not clear on flush.
- count: registered; equals popcount of v[] after each edge.
  - Update is count + in_xfer - out_xfer (each 0/1), never exceeding DEPTH.
  - Flush sets it to 0.
- Protocol requirement on the producer: once asserted, in_valid must be held with stable in_data until accepted. The block does not check this.
- DEPTH=1: degenerates to a single enabled register with valid/ready; all rules above still apply.

Optional Feature:
- Macro: REGBLOCK_PIPE_STATS_EN.
- Defined:
  - Adds output stall_cnt, 32 bits: increments by 1 each cycle out_valid && !out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst; not cleared by flush.
  - Adds output full_seen, 1 bit: sticky, set when count==DEPTH; cleared by rst only.
- Undefined: these ports and their logic are absent. Core behaviour is identical in both builds.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in_data=32'h1234 -> after release out_valid=0, out_data=0, count=0, in_ready=1; nothing captured.
- Single word, DEPTH=3: push 32'hDEADBEEF at cycle 0, out_ready=1 -> out_valid=1 with out_data=32'hDEADBEEF at cycle 3 only; count=1 during cycles 1-3, 0 at cycle 4.
- Backpressure: out_ready=0, offer 32'hA1,A2,A3,A4 back to back -> A1-A3 accepted, count=3, in_ready=0 with A4 held. Raise out_ready -> outputs A1,A2,A3,A4 in order on consecutive cycles; A4 accepted in the same cycle A1 leaves.
- Streaming: out_ready=1, push 10 words 0..9 continuously -> in_ready stays 1, outputs 0..9 on cycles 3..12 with no gaps, count steady at 3 mid-stream.
- Flush mid-flight: two words in flight (count=2), assert flush one cycle with in_valid=1, in_data=32'h55 -> in_ready=0 that cycle; next cycle count=0, out_valid=0; 32'h55 never emerges.
- Stats (macro defined): hold out_ready=0 for 5 cycles with out_valid=1, then flush -> stall_cnt=5 and full_seen=1 if count reached 3; both unchanged by flush, both 0 after rst.
